// File: rtl/rx_challenge_ctrl_if.sv
// Signal bundle between the challenge controller, the serial receiver and the PUF core.
// master = controller side, slave = receiver/host/PUF side.
interface rx_challenge_ctrl_if #(
    parameter int WIDTH  = 8,
    parameter int NBYTES = 8
);
    logic                    rxd_line;
    logic                    rx_start;
    logic                    rx_done;
    logic [WIDTH-1:0]        rx_data;
    logic [NBYTES*WIDTH-1:0] chal_data;
    logic                    chal_valid;
    logic                    chal_ready;
    logic                    err_chk;
    logic                    err_timeout;
    logic                    busy;

    modport master (
        input  rxd_line, rx_done, rx_data, chal_ready,
        output rx_start, chal_data, chal_valid, err_chk, err_timeout, busy
    );

    modport slave (
        output rxd_line, rx_done, rx_data, chal_ready,
        input  rx_start, chal_data, chal_valid, err_chk, err_timeout, busy
    );
endinterface

// File: rtl/rx_challenge_ctrl.sv
// Hunts start bits, kicks the bit-serial receiver, assembles NBYTES challenge bytes plus
// an XOR checksum byte and presents the challenge to the PUF core via valid/ready.
module rx_challenge_ctrl #(
    parameter int WIDTH   = 8,
    parameter int NBYTES  = 8,
    parameter int GAP_MAX = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    rx_challenge_ctrl_if.master  bus
);
    localparam int CNT_W = $clog2(NBYTES + 1);
    localparam int GAP_W = $clog2(GAP_MAX + 1);
    localparam int TMR_W = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {HUNT, KICK, RECV, PRESENT} state_t;

    state_t                         state_q, state_n;
    logic [CNT_W-1:0]               byte_cnt_q, byte_cnt_n;
    logic [WIDTH-1:0]               xor_q, xor_n;
    logic [GAP_W-1:0]               gap_q, gap_n;
    logic [TMR_W-1:0]               tmr_q, tmr_n;
    logic [NBYTES-1:0][WIDTH-1:0]   asm_q, asm_n;
    logic [NBYTES-1:0][WIDTH-1:0]   chal_q, chal_n;
    logic                           chk_err_n, tmo_n;
    logic                           rx_start_q, chal_valid_q, err_chk_q, err_tmo_q, busy_q;

    always_comb begin
        state_n    = state_q;
        byte_cnt_n = byte_cnt_q;
        xor_n      = xor_q;
        gap_n      = gap_q;
        tmr_n      = '0;
        asm_n      = asm_q;
        chal_n     = chal_q;
        chk_err_n  = 1'b0;
        tmo_n      = 1'b0;
        case (state_q)
            HUNT: begin
                if (!bus.rxd_line) begin
                    state_n = KICK;
                    gap_n   = '0;
                end else if (byte_cnt_q != '0) begin
                    // The GAP_MAX-th consecutive idle cycle aborts the partial frame.
                    if (gap_q == GAP_W'(GAP_MAX - 1)) begin
                        tmo_n      = 1'b1;
                        byte_cnt_n = '0;
                        xor_n      = '0;
                        gap_n      = '0;
                    end else begin
                        gap_n = gap_q + GAP_W'(1);
                    end
                end
            end
            KICK: state_n = RECV;
            RECV: begin
                if (bus.rx_done) begin
                    if (byte_cnt_q != CNT_W'(NBYTES)) begin
                        for (int i = 0; i < NBYTES; i++)
                            if (byte_cnt_q == CNT_W'(i)) asm_n[i] = bus.rx_data;
                        xor_n      = xor_q ^ bus.rx_data;
                        byte_cnt_n = byte_cnt_q + CNT_W'(1);
                        state_n    = HUNT;
                    end else begin
                        if (bus.rx_data == xor_q) begin
                            chal_n  = asm_q;
                            state_n = PRESENT;
                        end else begin
                            chk_err_n = 1'b1;
                            state_n   = HUNT;
                        end
                        byte_cnt_n = '0;
                        xor_n      = '0;
                    end
                end else if (tmr_q == TMR_W'(WIDTH + 1)) begin
                    tmo_n      = 1'b1;
                    byte_cnt_n = '0;
                    xor_n      = '0;
                    state_n    = HUNT;
                end else begin
                    tmr_n = tmr_q + TMR_W'(1);
                end
            end
            PRESENT: if (bus.chal_ready) state_n = HUNT;
            default: state_n = HUNT;
        endcase
    end

    // Outputs are decoded from next-state values so they are flops aligned with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= HUNT;
            byte_cnt_q   <= '0;
            xor_q        <= '0;
            gap_q        <= '0;
            tmr_q        <= '0;
            asm_q        <= '0;
            chal_q       <= '0;
            rx_start_q   <= 1'b0;
            chal_valid_q <= 1'b0;
            err_chk_q    <= 1'b0;
            err_tmo_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_n;
            byte_cnt_q   <= byte_cnt_n;
            xor_q        <= xor_n;
            gap_q        <= gap_n;
            tmr_q        <= tmr_n;
            asm_q        <= asm_n;
            chal_q       <= chal_n;
            rx_start_q   <= (state_n == KICK);
            chal_valid_q <= (state_n == PRESENT);
            err_chk_q    <= chk_err_n;
            err_tmo_q    <= tmo_n;
            busy_q       <= (state_n != HUNT) || (byte_cnt_n != '0);
        end
    end

    assign bus.rx_start    = rx_start_q;
    assign bus.chal_data   = chal_q;
    assign bus.chal_valid  = chal_valid_q;
    assign bus.err_chk     = err_chk_q;
    assign bus.err_timeout = err_tmo_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_rx_challenge_ctrl.sv
// Random/directed frames through a behavioural receiver; outcomes predicted per frame
// from the byte list (XOR rule, pulse timing relative to the final rx_done).
module tb_rx_challenge_ctrl;
    localparam int W = 8, NB = 4, GM = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rx_challenge_ctrl_if #(.WIDTH(W), .NBYTES(NB)) bus();
    rx_challenge_ctrl #(.WIDTH(W), .NBYTES(NB), .GAP_MAX(GM)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int checks = 0, failures = 0, cyc = 0;
    bit tx_q[$];
    int ph = 0;
    logic [W-1:0] sh;
    int n_start, n_wide, n_done, n_chk, n_tmo, n_vrise, n_vcyc;
    int last_done, chk_cyc, tmo_cyc, vrise_cyc, rdy_delay, vage;
    bit prev_start, prev_valid, bp_inject;
    logic [NB*W-1:0] exp_chal = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] xsum(input logic [NB*W-1:0] d);
        logic [W-1:0] x = '0;
        for (int i = 0; i < NB; i++) x ^= d[i*W +: W];
        return x;
    endfunction

    task automatic clr_counts();
        n_start = 0; n_wide = 0; n_done = 0; n_chk = 0; n_tmo = 0; n_vrise = 0; n_vcyc = 0;
        last_done = -100; chk_cyc = -1; tmo_cyc = -1; vrise_cyc = -1;
    endtask

    // One clock: observe outputs mid-cycle, then drive this cycle's inputs.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (bus.rx_start === 1'b1) begin n_start++; if (prev_start) n_wide++; end
        prev_start = (bus.rx_start === 1'b1);
        if (bus.err_chk === 1'b1) begin n_chk++; chk_cyc = cyc; end
        if (bus.err_timeout === 1'b1) begin n_tmo++; tmo_cyc = cyc; end
        if (bus.chal_valid === 1'b1) begin
            if (!prev_valid) begin
                n_vrise++; vrise_cyc = cyc; vage = 0;
                if (bp_inject) begin
                    tx_q.push_back(1'b0); tx_q.push_back(1'b1); tx_q.push_back(1'b0);
                    tx_q.push_back(1'b1); tx_q.push_back(1'b0); tx_q.push_back(1'b1);
                end
            end
            n_vcyc++;
            if (bp_inject && vage < 10) chk("bp_hold_data", bus.chal_data, exp_chal);
        end
        prev_valid = (bus.chal_valid === 1'b1);

        bus.rxd_line = (tx_q.size() != 0) ? tx_q.pop_front() : 1'b1;
        bus.rx_done  = 1'b0;
        if (reset) ph = 0;
        else if (ph == W + 1) begin
            bus.rx_done = 1'b1; bus.rx_data = sh; ph = 0; n_done++; last_done = cyc;
        end else if (ph >= 1) begin
            sh[ph-1] = bus.rxd_line; ph++;
        end
        if (!reset && bus.rx_start === 1'b1) ph = 1;

        if (bus.chal_valid === 1'b1) begin
            bus.chal_ready = (vage >= rdy_delay);
            vage++;
        end else begin
            bus.chal_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic push_byte(input logic [W-1:0] b, input int nstop);
        tx_q.push_back(1'b0);
        tx_q.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < W; i++) tx_q.push_back(b[i]);
        repeat (nstop) tx_q.push_back(1'b1);
    endtask

    task automatic run_frame(input logic [NB*W-1:0] data, input logic [W-1:0] ck,
                             input int rd, input int nstop);
        int k;
        bit good;
        good = (ck == xsum(data));
        if (good) exp_chal = data;
        rdy_delay = rd;
        clr_counts();
        for (int i = 0; i < NB; i++) push_byte(data[i*W +: W], (nstop > 0) ? nstop : 1 + $urandom_range(0, 2));
        push_byte(ck, 1);
        k = 0;
        while (n_done < NB + 1 && k < 400) begin step(); k++; end
        if (n_done < NB + 1) chk("frame_rx_done_count", n_done, NB + 1);
        repeat (2) step();
        k = 0;
        while (bus.chal_valid === 1'b1 && k < 40) begin step(); k++; end
        step();
        if (good) begin
            chk("valid_pulses", n_vrise, 1);
            chk("valid_latency", vrise_cyc - last_done, 1);
            chk("valid_cycles", n_vcyc, rd + 1);
            chk("no_err_chk", n_chk, 0);
        end else begin
            chk("err_chk_pulses", n_chk, 1);
            chk("err_chk_latency", chk_cyc - last_done, 1);
            chk("no_valid", n_vrise, 0);
        end
        chk("chal_data", bus.chal_data, exp_chal);
        chk("rx_start_count", n_start, NB + 1);
        chk("rx_start_width", n_wide, 0);
        chk("no_timeout", n_tmo, 0);
        chk("idle_busy", bus.busy, 0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_rx_start"}, bus.rx_start, 0);
        chk({tag, "_chal_valid"}, bus.chal_valid, 0);
        chk({tag, "_err_chk"}, bus.err_chk, 0);
        chk({tag, "_err_timeout"}, bus.err_timeout, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_chal_data"}, bus.chal_data, 0);
    endtask

    initial begin
        logic [NB*W-1:0] d;
        logic [W-1:0] ck;
        int k;
        reset = 1'b1;
        bus.rxd_line = 1'b1; bus.rx_done = 1'b0; bus.rx_data = '0; bus.chal_ready = 1'b0;
        rdy_delay = 0; vage = 0; bp_inject = 0;
        clr_counts();
        repeat (3) step();
        chk_zero_outputs("reset");
        reset = 1'b0;
        repeat (3) step();

        // Directed good frame, then the same bytes with a bad checksum, then a good one.
        run_frame(32'h88442211, 8'hFF, 0, 0);
        run_frame(32'h88442211, 8'h00, 0, 0);
        d = 32'h5A3C_0F81;
        run_frame(d, xsum(d), 1, 1);

        // Inter-byte gap timeout.
        clr_counts();
        push_byte(8'hA5, 1); push_byte(8'h5A, 1);
        k = 0;
        while (n_done < 2 && k < 200) begin step(); k++; end
        chk("gap_bytes_seen", n_done, 2);
        step();
        chk("gap_busy_during", bus.busy, 1);
        repeat (GM + 6) step();
        chk("gap_tmo_pulses", n_tmo, 1);
        chk("gap_tmo_cycle", tmo_cyc - last_done, GM + 1);
        chk("gap_busy_after", bus.busy, 0);
        chk("gap_chal_kept", bus.chal_data, exp_chal);
        d = 32'hDEAD_BEEF;
        run_frame(d, xsum(d), 0, 0);

        // Backpressure with start bits sent while the challenge is held.
        bp_inject = 1;
        d = 32'h1357_9BDF;
        run_frame(d, xsum(d), 10, 0);
        bp_inject = 0;

        // Reset while byte 2 is being received.
        clr_counts();
        d = 32'hCAFE_F00D;
        for (int i = 0; i < NB; i++) push_byte(d[i*W +: W], 1);
        k = 0;
        while (!(n_done == 2 && ph > 0) && k < 200) begin step(); k++; end
        chk("rst_reached_byte2", n_done, 2);
        repeat (3) step();
        reset = 1'b1;
        tx_q.delete();
        step();
        chk_zero_outputs("midrst");
        reset = 1'b0;
        exp_chal = '0;
        repeat (2) step();
        run_frame(32'h04030201, 8'h04, 0, 0);

        // Random frames: mixed checksums, stop lengths and ready delays.
        for (int n = 0; n < 8; n++) begin
            d  = $urandom;
            ck = xsum(d);
            if ($urandom_range(0, 3) == 0) ck ^= 8'($urandom_range(1, 255));
            run_frame(d, ck, $urandom_range(0, 3), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rx_challenge_ctrl.md
# rx_challenge_ctrl

Sequencing controller for the bit-serial `receiver` (WIDTH bits, one bit per clk, LSB first). It hunts the serial line for start bits, pulses the receiver's `RxStart`, and collects NBYTES challenge bytes plus one XOR checksum byte. It then presents the assembled challenge to the PUF core with a valid/ready handshake. It sits between the host serial link and the PUF challenge input, and flags checksum and inter-byte timeout errors.

## Interface
- WIDTH, 8: bits per byte; must match the receiver's WIDTH.
- NBYTES, 8: challenge bytes per frame, excluding the checksum byte; must be ≥1.
- GAP_MAX, 64: maximum idle cycles allowed between bytes inside one frame.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high. Shared with the receiver.
- rxd_line  in  1  serial line. Idles high. Also wired to the receiver's RxD.
- rx_start  out  1  one-cycle pulse to the receiver's RxStart.
- rx_done  in  1  receiver RxDone, a one-cycle pulse.
- rx_data  in  WIDTH  receiver DataOut, sampled in the cycle where rx_done=1.
- chal_data  out  NBYTES*WIDTH  last accepted challenge. Byte 0 sits in bits [WIDTH-1:0].
- chal_valid  out  1  challenge available; held until the handshake completes.
- chal_ready  in  1  PUF core accepts the challenge.
- err_chk  out  1  one-cycle pulse on checksum mismatch.
- err_timeout  out  1  one-cycle pulse on inter-byte gap or receiver timeout.
- busy  out  1  high when the state is not HUNT or byte_cnt≠0.

## Operation
- Line format per byte:
  - cycle c: start bit, rxd_line=0.
  - cycle c+1: guard cycle, value ignored.
  - cycles c+2..c+1+WIDTH: data bits, LSB first.
  - then ≥1 stop cycle high.
- Frame: NBYTES bytes, then a checksum byte equal to the XOR of all NBYTES bytes.
- States:
  - HUNT: wait for rxd_line=0. When seen, go to KICK.
  - KICK: rx_start=1 for exactly this cycle; go to RECV.
  - RECV: wait for rx_done. rxd_line is ignored.
    - If rx_done arrives and byte_cnt<NBYTES: write rx_data into the assembly buffer slot byte_cnt, update xor_acc ^= rx_data, byte_cnt+1, go to HUNT.
    - If rx_done arrives and byte_cnt==NBYTES (checksum byte):
      - rx_data==xor_acc: copy the assembly buffer to chal_data, go to PRESENT.
      - otherwise: pulse err_chk and go to HUNT.
      - In both cases clear byte_cnt and xor_acc.
    - If rx_done has not arrived after WIDTH+2 cycles in RECV: pulse err_timeout, clear byte_cnt and xor_acc, go to HUNT.
  - PRESENT: chal_valid=1. Start bits on rxd_line are ignored (frames sent now are lost). When chal_ready=1, the handshake completes that cycle; drop chal_valid next cycle and go to HUNT.
- Gap timeout: in HUNT with byte_cnt≠0, gap_cnt counts consecutive cycles with rxd_line=1. When it reaches GAP_MAX, pulse err_timeout, clear byte_cnt and xor_acc, and remain in HUNT. gap_cnt clears on leaving HUNT and on timeout.
- chal_data changes only on a successful checksum. Error paths never modify it.
- A byte_cnt width of clog2(NBYTES+1) is sufficient. xor_acc is WIDTH bits. gap_cnt must hold GAP_MAX.

## Timing
- Reset values:
  - State HUNT.
  - rx_start, chal_valid, err_chk, err_timeout, busy = 0.
  - chal_data = 0.
  - byte_cnt, xor_acc, gap_cnt = 0.
- Reset mid-frame discards all partial data.
- All outputs are registered.
- Start bit in cycle c gives rx_start=1 in cycle c+1. Receiver rx_done arrives in cycle c+2+WIDTH.
- The earliest next start bit is at cycle c+3+WIDTH, after one stop cycle.
- For the checksum byte whose rx_done is in cycle d:
  - chal_valid=1 from cycle d+1, or err_chk=1 in cycle d+1 only.
- The handshake completes in a cycle with chal_valid=1 and chal_ready=1. HUNT resumes the next cycle; a start bit is accepted from that cycle.
- A chal_ready asserted before chal_valid has no effect.

## Test plan
- Frame test (NBYTES=4, WIDTH=8):
  - Stimulus: bytes 0x11, 0x22, 0x44, 0x88, checksum 0xFF, chal_ready=1.
  - Required: chal_data=0x88442211; chal_valid high for exactly 1 cycle, starting one cycle after the final rx_done; no error pulses.
- Same bytes with checksum 0x00:
  - err_chk pulses once; chal_valid stays 0; chal_data keeps its previous value; a following good frame is accepted.
- GAP_MAX=16, send 2 bytes, then hold the line high:
  - err_timeout pulses once, 16 cycles into the gap.
  - busy falls; a subsequent full frame yields correct chal_data.
- Backpressure: good frame with chal_ready=0 for 10 cycles, start bits sent meanwhile:
  - chal_valid and chal_data stay stable for 10 cycles.
  - The ignored start bits cause no rx_start.
  - Handshake completes on the first chal_ready=1.
- Back-to-back bytes with exactly one stop cycle:
  - All 5 bytes are captured; rx_start pulses 5 times, each 1 cycle wide.
- reset asserted during RECV of byte 2, then released:
  - All outputs return to 0 the next cycle.
  - A fresh frame 0x01, 0x02, 0x03, 0x04, checksum 0x04 gives chal_data=0x04030201.
